// File: rtl/dmem_port.sv
// Data-memory load/store responder over a word-organised synchronous RAM.
// Build option: define DMEM_MISALIGN_TRAP_EN to fault on misaligned accesses instead of rounding them down.
module dmem_port #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        access_fault
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];
  logic [31:0] ram_dout;

  logic [2:0]  ld_funct3_q, ld_funct3_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        load_pending_q, load_pending_d;
  logic [31:0] rdata_q, rdata_d;
  logic        access_fault_q, access_fault_d;

  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]  eff_off;
  logic        is_half, is_word;
  logic        align_fault;
  logic        ld_size_ok, st_size_ok;
  logic        st_go, ld_go;
  logic [3:0]  byte_en;
  logic [31:0] wdata_rep;
  logic [31:0] load_val;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        unused_addr;

  // Address bits above the RAM depth alias onto the same words.
  assign unused_addr = &{1'b0, addr[31:ADDR_BITS+2]};

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
`endif

  always_comb begin
    word_idx   = addr[ADDR_BITS+1:2];
    is_half    = (funct3[1:0] == 2'b01);
    is_word    = (funct3[1:0] == 2'b10);
    ld_size_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    st_size_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
`ifdef DMEM_MISALIGN_TRAP_EN
    misaligned  = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    align_fault = misaligned;
    eff_off     = addr[1:0];
`else
    // Misaligned halfwords round to even, words to the word boundary.
    align_fault = 1'b0;
    eff_off     = addr[1:0];
    if (is_word) begin
      eff_off = 2'b00;
    end else if (is_half) begin
      eff_off = {addr[1], 1'b0};
    end
`endif
    st_go = dmem_write && st_size_ok && !align_fault && !reset;
    ld_go = dmem_read && !dmem_write && ld_size_ok && !align_fault && !reset;

    case (funct3[1:0])
      2'b00:   byte_en = 4'b0001 << eff_off;
      2'b01:   byte_en = eff_off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase

    case (funct3[1:0])
      2'b00:   wdata_rep = {4{wdata[7:0]}};
      2'b01:   wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (st_go) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
    if (ld_go) begin
      ram_dout <= mem[word_idx];
    end
  end

  // Stage-1 lane select works straight off the RAM output so data is usable in the cycle after the request.
  always_comb begin
    lane_half = ld_off_q[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (ld_off_q)
      2'b00:   lane_byte = ram_dout[7:0];
      2'b01:   lane_byte = ram_dout[15:8];
      2'b10:   lane_byte = ram_dout[23:16];
      default: lane_byte = ram_dout[31:24];
    endcase
    case (ld_funct3_q)
      3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_val = {24'h000000, lane_byte};
      3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_val = {16'h0000, lane_half};
      default: load_val = ram_dout;
    endcase
    rdata = load_pending_q ? load_val : rdata_q;
  end

  always_comb begin
    load_pending_d = ld_go;
    ld_funct3_d    = ld_go ? funct3 : ld_funct3_q;
    ld_off_d       = ld_go ? eff_off : ld_off_q;
    rdata_d        = rdata;
    access_fault_d = !reset && ((dmem_write && !st_go) ||
                                (dmem_read && !dmem_write && !ld_go));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_pending_q <= 1'b0;
      ld_funct3_q    <= 3'b000;
      ld_off_q       <= 2'b00;
      rdata_q        <= 32'h0;
      access_fault_q <= 1'b0;
    end else begin
      load_pending_q <= load_pending_d;
      ld_funct3_q    <= ld_funct3_d;
      ld_off_q       <= ld_off_d;
      rdata_q        <= rdata_d;
      access_fault_q <= access_fault_d;
    end
  end

  assign access_fault = access_fault_q;

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port with a byte-level memory model checked every cycle.
// Honours DMEM_MISALIGN_TRAP_EN the same way the design does.
module tb_dmem_port;

  logic        clk;
  logic        reset;
  logic        dmem_read;
  logic        dmem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        access_fault;

  int vec_count;
  int miss_count;

  logic [7:0]  mbytes [4096];
  logic [31:0] exp_rdata;
  logic        exp_fault;
  logic        model_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  dmem_port #(.ADDR_BITS(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .access_fault (access_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [11:0] base);
    logic [31:0] v;
    logic [11:0] idx;
    int n;
    n = 1 << f3[1:0];
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      idx = base + 12'(i);
      v[8*i +: 8] = mbytes[idx];
    end
    if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Model: what each request must leave on the outputs for the following cycle(s).
  always @(posedge clk) begin : model_blk
    logic [11:0] base;
    logic [11:0] idx;
    logic        bad_align;
    logic        ld_legal;
    logic        st_legal;
    int          n;
    if (reset) begin
      if (!model_ready) begin
        for (int i = 0; i < 4096; i++) mbytes[i] = 8'h00;
      end
      exp_rdata   = 32'h0;
      exp_fault   = 1'b0;
      model_ready = 1'b1;
    end else begin
      n         = 1 << funct3[1:0];
      base      = addr[11:0] & ~12'(n - 1);
      bad_align = TRAP && (addr[11:0] != base);
      ld_legal  = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      st_legal  = (funct3 inside {3'b000, 3'b001, 3'b010});
      exp_fault = 1'b0;
      if (dmem_write) begin
        if (!st_legal || bad_align) begin
          exp_fault = 1'b1;
        end else begin
          for (int i = 0; i < n; i++) begin
            idx = base + 12'(i);
            mbytes[idx] = wdata[8*i +: 8];
          end
        end
      end else if (dmem_read) begin
        if (!ld_legal || bad_align) exp_fault = 1'b1;
        else exp_rdata = model_load(funct3, base);
      end
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      vec_count++;
      if (rdata !== exp_rdata || access_fault !== exp_fault) begin
        miss_count++;
        $display("[TB] FAIL cycle_cmp t=%0t: got rdata=%h fault=%b, want rdata=%h fault=%b",
                 $time, rdata, access_fault, exp_rdata, exp_fault);
      end
    end
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    dmem_read  = rd;
    dmem_write = wr;
    funct3     = f3;
    addr       = a;
    wdata      = wd;
    @(posedge clk);
    #1;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    wdata      = 32'h0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] want_rd, input logic want_f);
    vec_count++;
    if (rdata !== want_rd || access_fault !== want_f) begin
      miss_count++;
      $display("[TB] FAIL %s: got rdata=%h fault=%b, want rdata=%h fault=%b",
               name, rdata, access_fault, want_rd, want_f);
    end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vec_count   = 0;
    miss_count  = 0;
    model_ready = 1'b0;
    exp_rdata   = 32'h0;
    exp_fault   = 1'b0;
    reset       = 1'b1;
    dmem_read   = 1'b0;
    dmem_write  = 1'b0;
    funct3      = 3'b000;
    addr        = 32'h0;
    wdata       = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset", 32'h0, 1'b0);

    for (int w = 0; w < 16; w++) applyStimulus(1'b0, 1'b1, 3'b010, 32'(w * 4), 32'h0);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    checkOutput("lw_0", 32'h00000000, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
    checkOutput("sw_8", 32'h00000000, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h8, 32'h0);
    checkOutput("lw_8", 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h9, 32'h00000080);
    checkOutput("sb_9", 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h9, 32'h0);
    checkOutput("lb_9", 32'hFFFFFF80, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h9, 32'h0);
    checkOutput("lbu_9", 32'h00000080, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h8, 32'h0);
    checkOutput("lw_8_merged", 32'hDEAD80EF, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'hA, 32'h0);
    checkOutput("lh_a", 32'hFFFFDEAD, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'hA, 32'h0);
    checkOutput("lhu_a", 32'h0000DEAD, 1'b0);

    applyStimulus(1'b0, 1'b1, 3'b010, 32'h5, 32'h12345678);
    checkOutput("sw_misaligned", 32'h0000DEAD, TRAP);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    checkOutput("lw_4", TRAP ? 32'h00000000 : 32'h12345678, 1'b0);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h8, 32'h0);
    checkOutput("lw_8_again", 32'hDEAD80EF, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h8, 32'h0);
    checkOutput("ld_illegal", 32'hDEAD80EF, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'b011, 32'h8, 32'h0);
    checkOutput("st_illegal", 32'hDEAD80EF, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h1008, 32'h0);
    checkOutput("lw_alias", 32'hDEAD80EF, 1'b0);

    applyStimulus(1'b1, 1'b1, 3'b010, 32'hC, 32'hCAFEF00D);
    checkOutput("rd_wr_both", 32'hDEAD80EF, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'hC, 32'h0);
    checkOutput("lw_c", 32'hCAFEF00D, 1'b0);

    applyStimulus(1'b1, 1'b0, 3'b001, 32'h9, 32'h0);
    checkOutput("lh_misaligned", TRAP ? 32'hCAFEF00D : 32'hFFFF80EF, TRAP);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'hE, 32'h00001234);
    checkOutput("sh_e", TRAP ? 32'hCAFEF00D : 32'hFFFF80EF, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'hC, 32'h0);
    checkOutput("lw_c_half", 32'h1234F00D, 1'b0);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    checkOutput("b2b_first", 32'h00000000, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h8, 32'h0);
    checkOutput("b2b_second", 32'hDEAD80EF, 1'b0);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'hC, 32'h0);
    checkOutput("lw_before_reset", 32'h1234F00D, 1'b0);
    pulseReset();
    checkOutput("mid_load_reset", 32'h00000000, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'hC, 32'h0);
    checkOutput("lw_after_reset", 32'h1234F00D, 1'b0);

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
